aes_byte_loader: RTL and testbench

Byte-serial front end that feeds the AES encrypt/decrypt cores. It assembles an `nk`-word key and then a stream of 128-bit blocks from an 8-bit valid/ready input. It presents them as `key_out` (held) and `block_out` (valid/ready), so the cipher no longer depends on hard-coded key and state registers. Assembly is double-buffered: one block assembles while the previous one waits for the consumer.

---
 rtl/aes_byte_loader.sv | 160 ++++++++++++++++
 tb/tb_aes_byte_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_loader.sv
// aes_byte_loader: byte-serial front end for the AES cores.
// Collects an nk-word key, then 128-bit blocks, from an 8-bit valid/ready
// stream. The first byte received lands in the MSB. The block path is
// double-buffered: an assembly register feeds a single output slot.
// Optional feature macro: AES_LOADER_ZEROPAD_EN (zero-pad short blocks
// terminated by in_last instead of discarding them).
module aes_byte_loader #(
    parameter int nk = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              rekey,
    output logic [nk*32-1:0]  key_out,
    output logic              key_valid,
    output logic [127:0]      block_out,
    output logic              block_valid,
    input  logic              block_ready,
    output logic              err_partial
);
    localparam int KW = nk * 32;
    localparam int KB = nk * 4;
    localparam int CW = $clog2(KB);
    localparam logic [CW-1:0] KEY_LAST  = CW'(KB - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(15);

    typedef enum logic {LOAD_KEY, LOAD_DATA} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [127:0]   asm_q;
    logic           asm_full;
    logic           accept;
    logic           slot_free;
    logic [127:0]   asm_shift;

    // Byte shifted in at the LSB end so the first byte ends up as the MSB.
    assign asm_shift = {asm_q[119:0], in_data};
    // Output slot can take the assembly if empty or drained on this edge.
    assign slot_free = !block_valid || block_ready;

`ifdef AES_LOADER_ZEROPAD_EN
    logic [3:0]   pad_bytes;
    logic [127:0] asm_padded;
    // Left-justify a short block; with cnt==15 the shift is zero.
    assign pad_bytes  = 4'd15 - cnt[3:0];
    assign asm_padded = asm_shift << {pad_bytes, 3'b000};
    assign err_partial = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD_KEY;
        else       state <= state_next;
    end

    // Next state and input handshake; in_ready depends on registered state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        if (!reset) begin
            case (state)
                LOAD_KEY:  in_ready = 1'b1;
                LOAD_DATA: in_ready = !asm_full;
                default:   in_ready = 1'b0;
            endcase
        end
        // rekey wins over a coincident byte: the byte is dropped.
        accept = in_valid && in_ready && !rekey;
        if (rekey)
            state_next = LOAD_KEY;
        else if (state == LOAD_KEY && accept && cnt == KEY_LAST)
            state_next = LOAD_DATA;
    end

    // Key shift register and its valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out   <= '0;
            key_valid <= 1'b0;
        end else if (rekey) begin
            key_valid <= 1'b0;
        end else if (accept && state == LOAD_KEY) begin
            key_out <= {key_out[KW-9:0], in_data};
            if (cnt == KEY_LAST) key_valid <= 1'b1;
        end
    end

    // Byte counter and block assembly register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            asm_q    <= '0;
            asm_full <= 1'b0;
`ifndef AES_LOADER_ZEROPAD_EN
            err_partial <= 1'b0;
`endif
        end else begin
`ifndef AES_LOADER_ZEROPAD_EN
            err_partial <= 1'b0;
`endif
            if (rekey) begin
                cnt      <= '0;
                asm_q    <= '0;
                asm_full <= 1'b0;
            end else begin
                // Hand-off to the output slot; never overlaps a data accept
                // because in_ready is low while the assembly is full.
                if (asm_full && slot_free) begin
                    asm_q    <= '0;
                    asm_full <= 1'b0;
                end
                if (accept && state == LOAD_KEY) begin
                    cnt <= (cnt == KEY_LAST) ? '0 : cnt + CW'(1);
                end else if (accept) begin
`ifdef AES_LOADER_ZEROPAD_EN
                    if (cnt == DATA_LAST || in_last) begin
                        asm_q    <= asm_padded;
                        asm_full <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        asm_q <= asm_shift;
                        cnt   <= cnt + CW'(1);
                    end
`else
                    if (cnt == DATA_LAST) begin
                        asm_q    <= asm_shift;
                        asm_full <= 1'b1;
                        cnt      <= '0;
                    end else if (in_last) begin
                        asm_q       <= '0;
                        cnt         <= '0;
                        err_partial <= 1'b1;
                    end else begin
                        asm_q <= asm_shift;
                        cnt   <= cnt + CW'(1);
                    end
`endif
                end
            end
        end
    end

    // Output slot: refilled on the consume edge so valid stays high back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_out   <= '0;
            block_valid <= 1'b0;
        end else if (asm_full && slot_free && !rekey) begin
            block_out   <= asm_q;
            block_valid <= 1'b1;
        end else if (block_valid && block_ready) begin
            block_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: two instances (nk=4 and nk=8) on a shared
// clock/reset. Blocks from the nk=4 instance go through a scoreboard queue.
module tb_aes_byte_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][7:0]   in_data;
    logic [1:0]        in_valid, in_last, rekey, in_ready;
    logic [1:0]        key_valid, block_valid, block_ready, err_partial;
    logic [1:0][127:0] block_out;
    logic [127:0]      key_out4;
    logic [255:0]      key_out8;

    aes_byte_loader #(.nk(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_last(in_last[0]), .rekey(rekey[0]),
        .key_out(key_out4), .key_valid(key_valid[0]), .block_out(block_out[0]),
        .block_valid(block_valid[0]), .block_ready(block_ready[0]),
        .err_partial(err_partial[0]));

    aes_byte_loader #(.nk(8)) dut8 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_last(in_last[1]), .rekey(rekey[1]),
        .key_out(key_out8), .key_valid(key_valid[1]), .block_out(block_out[1]),
        .block_valid(block_valid[1]), .block_ready(block_ready[1]),
        .err_partial(err_partial[1]));

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q[$];

    typedef struct {
        logic [127:0] din;      // bytes to send, left-justified
        int           n;        // number of bytes sent
        bit           last;     // in_last on the final byte
        logic [127:0] exp_blk;  // expected block (padded form for short ones)
        bit           partial;  // short block terminated by in_last
    } vec_t;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(int u, logic [7:0] b, logic last);
        int n;
        n = 0;
        in_data[u]  = b;
        in_last[u]  = last;
        in_valid[u] = 1'b1;
        while (!in_ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: unit %0d got in_ready=0 expected 1", u);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb_q.size(), 0);
    endtask

    // Scoreboard monitor: compares each block as it transfers.
    always @(negedge clk) begin
        logic [127:0] e;
        #2;
        if (!reset && block_valid[0] && block_ready[0]) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got %h expected none", block_out[0]);
            end else begin
                e = sb_q.pop_front();
                check("block_out", block_out[0], e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{128'h0123456789abcdeffedcba9876543210, 16, 1'b0,
                    128'h0123456789abcdeffedcba9876543210, 1'b0};
        vecs[1] = '{128'hdeadbeefcafef00d0badc0de12345678, 16, 1'b1,
                    128'hdeadbeefcafef00d0badc0de12345678, 1'b0};
        vecs[2] = '{128'haabbcc00000000000000000000000000, 3, 1'b1,
                    128'haabbcc00000000000000000000000000, 1'b1};
        vecs[3] = '{128'h5a000000000000000000000000000000, 1, 1'b1,
                    128'h5a000000000000000000000000000000, 1'b1};
        vecs[4] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1ff, 15, 1'b1,
                    128'h0f1e2d3c4b5a69788796a5b4c3d2e100, 1'b1};
        vecs[5] = '{128'h11111111222222223333333344444444, 16, 1'b0,
                    128'h11111111222222223333333344444444, 1'b0};

        in_data = '0; in_valid = '0; in_last = '0; rekey = '0; block_ready = 2'b11;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 2'b00);
        check("rst_key_valid", key_valid, 2'b00);
        check("rst_block_valid", block_valid, 2'b00);
        check("rst_err", err_partial, 2'b00);
        check("rst_key_out4", key_out4, 0);
        check("rst_block_out4", block_out[0], 0);
        reset = 1'b0;
        @(negedge clk);
        check("key_in_ready", in_ready, 2'b11);

        // Key load, nk=4; in_last on a key byte must be ignored.
        for (int i = 0; i < 15; i++) send_byte(0, 8'(i), i == 5);
        check("key_valid_early", key_valid[0], 1'b0);
        send_byte(0, 8'd15, 1'b0);
        check("key_valid4", key_valid[0], 1'b1);
        check("key_out4", key_out4, 128'h000102030405060708090a0b0c0d0e0f);
        check("data_in_ready", in_ready[0], 1'b1);

        // Single block with the consumer ready: timing of valid and in_ready.
        for (int i = 0; i < 16; i++) send_byte(0, 8'(i * 17), 1'b0);
        sb_q.push_back(128'h00112233445566778899aabbccddeeff);
        check("full_in_ready", in_ready[0], 1'b0);
        check("full_bv_pending", block_valid[0], 1'b0);
        @(negedge clk);
        check("single_bv_high", block_valid[0], 1'b1);
        @(negedge clk);
        check("single_bv_low", block_valid[0], 1'b0);
        check("single_in_ready", in_ready[0], 1'b1);
        drain();

        // Table of full and short blocks.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(0, vecs[v].din[127 - 8*i -: 8], vecs[v].last && (i == vecs[v].n - 1));
            if (!vecs[v].partial) begin
                sb_q.push_back(vecs[v].exp_blk);
            end else begin
`ifdef AES_LOADER_ZEROPAD_EN
                sb_q.push_back(vecs[v].exp_blk);
                check("zp_err_tied", err_partial[0], 1'b0);
`else
                check("err_pulse_hi", err_partial[0], 1'b1);
                @(negedge clk);
                check("err_pulse_lo", err_partial[0], 1'b0);
                check("err_no_block", block_valid[0], 1'b0);
`endif
            end
            drain();
        end

        // Backpressure: two blocks with the consumer stalled.
        block_ready[0] = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(0, 8'(8'h20 + i), 1'b0);
        sb_q.push_back(128'h202122232425262728292a2b2c2d2e2f);
        for (int i = 0; i < 16; i++) send_byte(0, 8'(8'h80 + i), 1'b0);
        sb_q.push_back(128'h808182838485868788898a8b8c8d8e8f);
        check("bp_in_ready", in_ready[0], 1'b0);
        check("bp_valid", block_valid[0], 1'b1);
        check("bp_hold1", block_out[0], 128'h202122232425262728292a2b2c2d2e2f);
        repeat (3) @(negedge clk);
        check("bp_hold2", block_out[0], 128'h202122232425262728292a2b2c2d2e2f);
        check("bp_in_ready2", in_ready[0], 1'b0);
        block_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_b2_valid", block_valid[0], 1'b1);
        check("bp_b2_out", block_out[0], 128'h808182838485868788898a8b8c8d8e8f);
        check("bp_in_ready3", in_ready[0], 1'b1);
        drain();

        // nk=8 key, partial data, rekey with a coincident byte, new key.
        for (int i = 0; i < 32; i++) send_byte(1, 8'(i), 1'b0);
        check("key_valid8", key_valid[1], 1'b1);
        check("key_out8", key_out8,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        for (int i = 0; i < 5; i++) send_byte(1, 8'(8'hc0 + i), 1'b0);
        in_data[1] = 8'hee; in_valid[1] = 1'b1; rekey[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0; rekey[1] = 1'b0;
        check("rekey_kv", key_valid[1], 1'b0);
        check("rekey_in_ready", in_ready[1], 1'b1);
        for (int i = 0; i < 32; i++) send_byte(1, 8'(8'h20 + i), 1'b0);
        check("rekey_kv2", key_valid[1], 1'b1);
        check("rekey_key8", key_out8,
              256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
        for (int i = 0; i < 16; i++) send_byte(1, 8'(8'h40 + i), 1'b0);
        for (int n = 0; n < 5 && !block_valid[1]; n++) @(negedge clk);
        check("rekey_bv8", block_valid[1], 1'b1);
        check("rekey_blk8", block_out[1], 128'h404142434445464748494a4b4c4d4e4f);

        // Reset in the middle of a block.
        for (int i = 0; i < 7; i++) send_byte(0, 8'(8'h60 + i), 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_key_out", key_out4, 0);
        check("mid_rst_kv", key_valid[0], 1'b0);
        check("mid_rst_bout", block_out[0], 0);
        check("mid_rst_bv", block_valid[0], 1'b0);
        check("mid_rst_err", err_partial[0], 1'b0);
        check("mid_rst_in_ready", in_ready[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_kv", key_valid[0], 1'b0);
        check("post_rst_in_ready", in_ready[0], 1'b1);
        for (int i = 0; i < 16; i++) send_byte(0, 8'(8'ha0 + i), 1'b0);
        check("post_rst_kv2", key_valid[0], 1'b1);
        check("post_rst_key", key_out4, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
